// File: rtl/shiftreg_ctrl.sv
// rtl/shiftreg_ctrl.sv - Word-to-serial controller driving a 6-bit left shift register
// Optional even-parity bit after each frame: define SHIFTREG_CTRL_PARITY_EN.
module shiftreg_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       sr_load,
    output logic [5:0] sr_data,
    output logic       sr_en,
    input  logic       sr_msb,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_done,
    output logic       busy
);

`ifdef SHIFTREG_CTRL_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_PAR, ST_GAP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [5:0] hold, hold_n;
    logic [7:0] div, div_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] gap_cnt, gap_cnt_n;
    logic       idle_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            hold    <= '0;
            div     <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            hold    <= hold_n;
            div     <= div_n;
            bit_cnt <= bit_cnt_n;
            gap_cnt <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_n     = hold;
        div_n      = div;
        bit_cnt_n  = bit_cnt;
        gap_cnt_n  = gap_cnt;
        idle_ready = 1'b0;
        sr_load    = 1'b0;
        sr_en      = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (in_valid) begin
                    hold_n    = in_data;
                    div_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_load = 1'b1;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = sr_msb;
                if (div == DIV_LAST) begin
                    sr_en     = 1'b1;
                    div_n     = '0;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd5) begin
                        bit_cnt_n = '0;
                        gap_cnt_n = '0;
`ifdef SHIFTREG_CTRL_PARITY_EN
                        state_n   = ST_PAR;
`else
                        state_n   = ST_GAP;
`endif
                    end
                end else begin
                    div_n = div + 8'd1;
                end
            end
`ifdef SHIFTREG_CTRL_PARITY_EN
            ST_PAR: begin
                ser_valid = 1'b1;
                ser_out   = ^hold;
                if (div == DIV_LAST) begin
                    div_n     = '0;
                    gap_cnt_n = '0;
                    state_n   = ST_GAP;
                end else begin
                    div_n = div + 8'd1;
                end
            end
`endif
            ST_GAP: begin
                // gap_cnt is cleared on entry, so zero marks the first gap cycle
                frame_done = (gap_cnt == 8'd0);
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Held low during reset so upstream never sees a handshake that the reset would discard
    assign in_ready = idle_ready & ~rst;
    assign sr_data  = hold;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb/tb_shiftreg_ctrl.sv - Directed self-checking bench for shiftreg_ctrl
// Honours SHIFTREG_CTRL_PARITY_EN when the build defines it.
module tb_shiftreg_ctrl;

`ifdef SHIFTREG_CTRL_PARITY_EN
    localparam int P_EN = 1;
`else
    localparam int P_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv_a, ir_a, ld_a, en_a, msb_a, so_a, sv_a, fd_a, busy_a;
    logic       iv_b, ir_b, ld_b, en_b, msb_b, so_b, sv_b, fd_b, busy_b;
    logic [5:0] id_a, sd_a, id_b, sd_b;
    logic [5:0] sr_a = '0;
    logic [5:0] sr_b = '0;
    int n_cmp = 0;
    int n_bad = 0;

    shiftreg_ctrl dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .sr_load(ld_a), .sr_data(sd_a), .sr_en(en_a), .sr_msb(msb_a),
        .ser_out(so_a), .ser_valid(sv_a), .frame_done(fd_a), .busy(busy_a)
    );

    shiftreg_ctrl #(.CLKS_PER_BIT(1), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
        .sr_load(ld_b), .sr_data(sd_b), .sr_en(en_b), .sr_msb(msb_b),
        .ser_out(so_b), .ser_valid(sv_b), .frame_done(fd_b), .busy(busy_b)
    );

    // Downstream 6-bit left shift registers; not cleared by system reset
    always @(posedge clk) begin
        if (ld_a) sr_a <= sd_a;
        else if (en_a) sr_a <= {sr_a[4:0], 1'b0};
        if (ld_b) sr_b <= sd_b;
        else if (en_b) sr_b <= {sr_b[4:0], 1'b0};
    end
    assign msb_a = sr_a[5];
    assign msb_b = sr_b[5];

    function automatic logic [6:0] obs(input bit sel);
        if (sel) return {ld_b, en_b, sv_b, so_b, fd_b, busy_b, ir_b};
        return {ld_a, en_a, sv_a, so_a, fd_a, busy_a, ir_a};
    endfunction

    task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s {ld,en,sv,so,fd,busy,rdy} observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] o, input logic [5:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s sr_data observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [5:0] d);
        if (sel) begin iv_b = v; id_b = d; end
        else begin iv_a = v; id_a = d; end
    endtask

    // Entered at the negedge of handshake cycle T; walks T+1 .. return to IDLE.
    task automatic run_frame(input bit sel, input int c, input int g, input logic [5:0] w,
                             input bit keep, input logic [5:0] nxt, input bit poke,
                             input string tag);
        int p, last;
        logic [6:0] e;
        logic [5:0] sh;
        logic so;
        p = (P_EN != 0) ? c : 0;
        last = 2 + 6*c + p + g;
        chk($sformatf("%s t0", tag), obs(sel), 7'b0000001);
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == 1) drive(sel, keep, keep ? nxt : ~w);
            if (poke && t == 10) drive(sel, 1'b1, w ^ 6'h3F);
            if (poke && t == 11) drive(sel, 1'b0, ~w);
            so = 1'b0;
            if (t >= 2 && t <= 1 + 6*c) begin
                sh = w << ((t - 2) / c);
                so = sh[5];
            end else if (t > 1 + 6*c && t <= 1 + 6*c + p) begin
                so = ^w;
            end
            e = {t == 1,
                 (t >= 2 && t <= 1 + 6*c && ((t - 1) % c) == 0),
                 (t >= 2 && t <= 1 + 6*c + p),
                 so,
                 t == 2 + 6*c + p,
                 t < last,
                 t == last};
            chk($sformatf("%s t%0d", tag, t), obs(sel), e);
            chk6($sformatf("%s t%0d", tag, t), sel ? sd_b : sd_a, w);
        end
    endtask

    initial begin
        iv_a = 1'b0; id_a = '0; iv_b = 1'b0; id_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a", obs(0), 7'b0);
        chk("reset_b", obs(1), 7'b0);
        chk6("reset_a", sd_a, 6'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("release_a", obs(0), 7'b0000001);
        chk("release_b", obs(1), 7'b0000001);

        drive(0, 1'b1, 6'b101100);
        run_frame(0, 4, 2, 6'b101100, 1'b0, 6'h00, 1'b0, "w2c");

        drive(0, 1'b1, 6'h2A);
        run_frame(0, 4, 2, 6'h2A, 1'b1, 6'h15, 1'b0, "b2b_first");
        run_frame(0, 4, 2, 6'h15, 1'b0, 6'h00, 1'b0, "b2b_second");

        drive(0, 1'b1, 6'b010011);
        run_frame(0, 4, 2, 6'b010011, 1'b0, 6'h00, 1'b1, "poke");

        drive(0, 1'b1, 6'b110000);
        run_frame(0, 4, 2, 6'b110000, 1'b0, 6'h00, 1'b0, "par0");

        // Abort a frame mid-SHIFT with a 3-cycle reset
        drive(0, 1'b1, 6'b111000);
        @(negedge clk);
        drive(0, 1'b0, 6'h00);
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", obs(0) & 7'b0000010, 7'b0000010);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_rst%0d", i), obs(0), 7'b0);
            chk6($sformatf("abort_rst%0d", i), sd_a, 6'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle%0d", i), obs(0), 7'b0000001);
        end

        drive(1, 1'b1, 6'b111111);
        run_frame(1, 1, 1, 6'b111111, 1'b0, 6'h00, 1'b0, "fast_3f");
        drive(1, 1'b1, 6'b100101);
        run_frame(1, 1, 1, 6'b100101, 1'b0, 6'h00, 1'b0, "fast_25");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
